// File: rtl/surf5_debug_regs_if.sv
// rtl/surf5_debug_regs_if.sv - Wishbone classic bus bundle for the SURF5 debug register block.
interface surf5_debug_regs_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [19:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/surf5_debug_regs.sv
// rtl/surf5_debug_regs.sv - SURF5 debug registers: ID, scratch, control, timer, event counter, timer snapshot.
module surf5_debug_regs #(
  parameter logic [31:0] ID_VALUE        = 32'h53463544,
  parameter int          ERR_ON_UNMAPPED = 1
) (
  input  logic                  wbc_clk_i,
  input  logic                  rst_n_i,
  surf5_debug_regs_if.slave     wb,
  input  logic                  event_i,
  output logic [1:0]            ila0_sel_o,
  output logic [7:0]            global_debug_o
);

  localparam bit ERR_EN = (ERR_ON_UNMAPPED != 0);

  localparam logic [2:0] IDX_ID      = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_CTRL    = 3'd2;
  localparam logic [2:0] IDX_TIMER   = 3'd3;
  localparam logic [2:0] IDX_EVCNT   = 3'd4;
  localparam logic [2:0] IDX_SNAP    = 3'd5;

  typedef enum logic [1:0] {IDLE, TERM, WAIT} state_t;

  state_t      state;
  logic [31:0] scratch;
  logic [1:0]  ctrl_lo;
  logic [7:0]  ctrl_hi;
  logic [31:0] timer;
  logic [31:0] evcnt;
  logic [31:0] snap;
  logic        ev_prev;

  logic        req_we;
  logic        req_hit;
  logic [2:0]  req_idx;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;

  logic [31:0] dat_q;
  logic        ack_q;
  logic        err_q;

  logic [2:0]  idx;
  logic        hit;
  logic [31:0] rd_val;
  logic        ev_rise;
  logic        wr_term;
  logic        ev_clear;

  assign idx      = wb.adr_i[4:2];
  assign hit      = (wb.adr_i[19:5] == 15'd0) && (idx < 3'd6);
  assign ev_rise  = event_i & ~ev_prev;
  assign wr_term  = (state == TERM) && req_we && req_hit;
  assign ev_clear = wr_term && (req_idx == IDX_EVCNT);

  always_comb begin
    rd_val = 32'h0;
    case (idx)
      IDX_ID:      rd_val = ID_VALUE;
      IDX_SCRATCH: rd_val = scratch;
      IDX_CTRL:    rd_val = {16'h0, ctrl_hi, 6'h0, ctrl_lo};
      IDX_TIMER:   rd_val = timer;
      IDX_EVCNT:   rd_val = evcnt;
      IDX_SNAP:    rd_val = snap;
      default:     rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge wbc_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer <= 32'h0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // A clear coincident with a new edge keeps that edge, hence 1 rather than 0.
  always_ff @(posedge wbc_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ev_prev <= 1'b0;
      evcnt   <= 32'h0;
    end else begin
      ev_prev <= event_i;
      if (ev_clear) begin
        evcnt <= ev_rise ? 32'd1 : 32'd0;
      end else if (ev_rise && (evcnt != 32'hFFFF_FFFF)) begin
        evcnt <= evcnt + 32'd1;
      end
    end
  end

  always_ff @(posedge wbc_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      scratch <= 32'h0;
      ctrl_lo <= 2'b00;
      ctrl_hi <= 8'h00;
      snap    <= 32'h0;
      req_we  <= 1'b0;
      req_hit <= 1'b0;
      req_idx <= 3'd0;
      req_dat <= 32'h0;
      req_sel <= 4'h0;
      dat_q   <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wb.cyc_i && wb.stb_i) begin
            state   <= TERM;
            req_we  <= wb.we_i;
            req_hit <= hit;
            req_idx <= idx;
            req_dat <= wb.dat_i;
            req_sel <= wb.sel_i;
            ack_q   <= hit || !ERR_EN;
            err_q   <= !hit && ERR_EN;
            dat_q   <= (!wb.we_i && hit) ? rd_val : 32'h0;
            if (!wb.we_i && hit && (idx == IDX_TIMER)) begin
              snap <= timer;
            end
          end
        end
        TERM: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          dat_q <= 32'h0;
          state <= wb.stb_i ? WAIT : IDLE;
          if (wr_term && (req_idx == IDX_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
              if (req_sel[b]) scratch[8*b +: 8] <= req_dat[8*b +: 8];
            end
          end
          if (wr_term && (req_idx == IDX_CTRL)) begin
            if (req_sel[0]) ctrl_lo <= req_dat[1:0];
            if (req_sel[1]) ctrl_hi <= req_dat[15:8];
          end
        end
        WAIT: begin
          if (!wb.stb_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.dat_o       = dat_q;
  assign wb.ack_o       = ack_q;
  assign wb.err_o       = err_q;
  assign wb.rty_o       = 1'b0;
  assign ila0_sel_o     = ctrl_lo;
  assign global_debug_o = ctrl_hi;

endmodule

// File: tb/tb_surf5_debug_regs.sv
// tb/tb_surf5_debug_regs.sv - directed self-checking bench for surf5_debug_regs.
module tb_surf5_debug_regs;

  logic       clk;
  logic       rst_n;
  logic       event_in;
  logic [1:0] ila0_sel;
  logic [7:0] global_debug;

  int checks;
  int failures;

  surf5_debug_regs_if bus();

  surf5_debug_regs dut (
    .wbc_clk_i      (clk),
    .rst_n_i        (rst_n),
    .wb             (bus),
    .event_i        (event_in),
    .ila0_sel_o     (ila0_sel),
    .global_debug_o (global_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_xfer(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata,
                         output logic got_ack, output logic got_err);
    int n;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr;  bus.dat_i = dat;  bus.sel_i = sel;
    n = 0; got_ack = 1'b0; got_err = 1'b0; rdata = 32'h0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (bus.ack_o || bus.err_o) begin
        got_ack = bus.ack_o; got_err = bus.err_o; rdata = bus.dat_o;
        break;
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL latency adr=%h got=%0d cycles expected=1", adr, n);
    end
  endtask

  task automatic pulse_event();
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    checks++; if (bus.rty_o !== 1'b0) begin failures++; $display("FAIL reset_rty got=%b exp=0", bus.rty_o); end
    checks++; if (bus.dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", bus.dat_o); end
    checks++; if (ila0_sel !== 2'b00) begin failures++; $display("FAIL reset_ila got=%b exp=00", ila0_sel); end
    checks++; if (global_debug !== 8'h00) begin failures++; $display("FAIL reset_gdbg got=%h exp=00", global_debug); end
  endtask

  task automatic test_id_read();
    logic [31:0] d; logic a, e;
    wb_xfer(1'b0, 20'h00000, 32'h0, 4'hF, d, a, e);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL id_ack got=%b exp=1", a); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL id_err got=%b exp=0", e); end
    checks++; if (d !== 32'h53463544) begin failures++; $display("FAIL id_data got=%h exp=53463544", d); end
    wb_xfer(1'b1, 20'h00000, 32'h12345678, 4'hF, d, a, e);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL id_write_ack got=%b exp=1", a); end
    wb_xfer(1'b0, 20'h00000, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h53463544) begin failures++; $display("FAIL id_after_write got=%h exp=53463544", d); end
  endtask

  task automatic test_scratch_bytes();
    logic [31:0] d; logic a, e;
    wb_xfer(1'b1, 20'h00004, 32'hDEADBEEF, 4'b0101, d, a, e);
    wb_xfer(1'b0, 20'h00004, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h00AD00EF) begin failures++; $display("FAIL scratch_lanes_0101 got=%h exp=00AD00EF", d); end
    wb_xfer(1'b1, 20'h00007, 32'h12345678, 4'b1010, d, a, e);
    wb_xfer(1'b0, 20'h00004, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h12AD56EF) begin failures++; $display("FAIL scratch_lanes_1010 got=%h exp=12AD56EF", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d; logic a, e;
    wb_xfer(1'b1, 20'h00008, 32'h0000A503, 4'hF, d, a, e);
    checks++; if (ila0_sel !== 2'b00) begin failures++; $display("FAIL ctrl_early_ila got=%b exp=00", ila0_sel); end
    @(negedge clk);
    checks++; if (ila0_sel !== 2'b11) begin failures++; $display("FAIL ctrl_ila got=%b exp=11", ila0_sel); end
    checks++; if (global_debug !== 8'hA5) begin failures++; $display("FAIL ctrl_gdbg got=%h exp=A5", global_debug); end
    wb_xfer(1'b0, 20'h00008, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h0000A503) begin failures++; $display("FAIL ctrl_read got=%h exp=0000A503", d); end
    wb_xfer(1'b1, 20'h00008, 32'hFFFFFFFF, 4'hF, d, a, e);
    wb_xfer(1'b0, 20'h00008, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h0000FF03) begin failures++; $display("FAIL ctrl_unimpl_bits got=%h exp=0000FF03", d); end
  endtask

  task automatic test_evcnt();
    logic [31:0] d; logic a, e;
    repeat (3) pulse_event();
    wb_xfer(1'b0, 20'h00010, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL evcnt_three got=%h exp=3", d); end
    wb_xfer(1'b1, 20'h00010, 32'h0, 4'hF, d, a, e);
    pulse_event();
    wb_xfer(1'b0, 20'h00010, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL evcnt_clear_then_one got=%h exp=1", d); end
    repeat (2) pulse_event();
    wb_xfer(1'b1, 20'h00010, 32'h0, 4'h0, d, a, e);
    event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
    wb_xfer(1'b0, 20'h00010, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL evcnt_clear_coincident got=%h exp=1", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic a, e;
    int errs, acks;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 20'h00040; bus.sel_i = 4'hF;
    errs = 0; acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL unmapped_err got=%b exp=1", bus.err_o); end
        checks++; if (bus.ack_o !== 1'b0) begin failures++; $display("FAIL unmapped_ack got=%b exp=0", bus.ack_o); end
        checks++; if (bus.dat_o !== 32'h0) begin failures++; $display("FAIL unmapped_dat got=%h exp=0", bus.dat_o); end
      end
      if (bus.err_o) errs++;
      if (bus.ack_o) acks++;
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    checks++; if (errs !== 1) begin failures++; $display("FAIL unmapped_err_pulses got=%0d exp=1", errs); end
    checks++; if (acks !== 0) begin failures++; $display("FAIL unmapped_ack_pulses got=%0d exp=0", acks); end
    wb_xfer(1'b1, 20'h00018, 32'hCAFEF00D, 4'hF, d, a, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL unmapped_write_err got=%b exp=1", e); end
    wb_xfer(1'b0, 20'h00004, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h12AD56EF) begin failures++; $display("FAIL unmapped_write_side_effect got=%h exp=12AD56EF", d); end
  endtask

  task automatic test_timer();
    logic [31:0] t1, t2, d; logic a, e;
    wb_xfer(1'b0, 20'h0000C, 32'h0, 4'hF, t1, a, e);
    repeat (10) @(negedge clk);
    wb_xfer(1'b0, 20'h0000C, 32'h0, 4'hF, t2, a, e);
    checks++; if ((t2 - t1) !== 32'd12) begin failures++; $display("FAIL timer_delta got=%0d exp=12", t2 - t1); end
    wb_xfer(1'b0, 20'h00014, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== t2) begin failures++; $display("FAIL timer_snap got=%h exp=%h", d, t2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic a, e;
    int acks;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 20'h00000;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack_o) acks++;
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    checks++; if (acks !== 1) begin failures++; $display("FAIL held_strobe_acks got=%0d exp=1", acks); end
    wb_xfer(1'b1, 20'h00004, 32'h0BADF00D, 4'hF, d, a, e);
    wb_xfer(1'b0, 20'h00004, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_scratch got=%h exp=0BADF00D", d); end
  endtask

  task automatic test_reset_mid_term();
    logic [31:0] d; logic a, e;
    int stray;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 20'h00000;
    @(posedge clk); #1;
    checks++; if (bus.ack_o !== 1'b1) begin failures++; $display("FAIL mid_term_pre_ack got=%b exp=1", bus.ack_o); end
    rst_n = 1'b0; #1;
    checks++; if (bus.ack_o !== 1'b0) begin failures++; $display("FAIL mid_term_ack got=%b exp=0", bus.ack_o); end
    checks++; if (bus.dat_o !== 32'h0) begin failures++; $display("FAIL mid_term_dat got=%h exp=0", bus.dat_o); end
    checks++; if ({ila0_sel, global_debug} !== 10'h0) begin failures++; $display("FAIL mid_term_ctrl got=%h exp=0", {ila0_sel, global_debug}); end
    @(negedge clk);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL mid_term_stray_term got=%0d exp=0", stray); end
    wb_xfer(1'b0, 20'h00004, 32'h0, 4'hF, d, a, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_term_scratch got=%h exp=0", d); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; event_in = 1'b0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = 20'h0; bus.dat_i = 32'h0; bus.sel_i = 4'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_id_read();
    test_scratch_bytes();
    test_ctrl();
    test_evcnt();
    test_unmapped();
    test_timer();
    test_back_to_back();
    test_reset_mid_term();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
